shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Bit-serial to parallel converter that sits directly downstream of the mixed shift/tree serializer and runs on the fast (bit) clock. It assembles WIDTH consecutive valid serial bits, LSB first, into one word and presents that word through a one-entry valid/ready output register. It detects frames that end early (abort) and words lost to back-pressure (overflow).

## Interface
- WIDTH, default 8: word width in bits; power of two, ≥ 2.
- LOGWIDTH, default 3: log2(WIDTH); sizes the bit counter.
- clk  in  1  bit clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- data_i  in  1  serial data bit, sampled when valid_i=1.
- valid_i  in  1  qualifies data_i; must stay high for exactly WIDTH cycles per word.
- data_o  out  WIDTH  assembled word; bit 0 = first received bit.
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i.
- abort_o  out  1  one-cycle pulse: valid_i dropped mid-word, partial word discarded.
- overflow_o  out  1  one-cycle pulse: completed word dropped because the output register was full.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE, valid_i=1: store data_i in shreg[0], set cnt to 1, go to SHIFT. IDLE, valid_i=0: hold.
- SHIFT, valid_i=1, cnt<WIDTH-1: store data_i in shreg[cnt], then cnt++.
- SHIFT, valid_i=1, cnt==WIDTH-1: the word is complete; the word is {data_i, shreg[WIDTH-2:0]}. Set cnt to 0 and go to IDLE.
- SHIFT, valid_i=0: pulse abort_o for 1 cycle, discard the partial word, set cnt to 0, go to IDLE.
- Back-to-back words need no gap. A valid bit in the cycle after completion starts the next word from IDLE.
- Output register behaviour at word completion:
  - If valid_o=0, or valid_o=1 and ready_i=1 in the same cycle: load data_o and set valid_o=1.
  - If valid_o=1 and ready_i=0: drop the new word, keep data_o and valid_o, pulse overflow_o.
- With no completion in the cycle, valid_o & ready_i clears valid_o. data_o keeps its last value and is don't-care while valid_o=0.
- cnt is LOGWIDTH bits wide and never passes WIDTH-1; there is no wrap other than the explicit clear.
- abort_o and overflow_o never assert in the same cycle.

## Timing
- Reset values: data_o=0, valid_o=0, abort_o=0, overflow_o=0, state=IDLE, cnt=0, shreg=0.
- Reset mid-word discards the partial word with no abort pulse. Reset while valid_o=1 discards the held word.
- Latency: last bit sampled at edge N; valid_o and data_o are visible after edge N (one register stage).
- abort_o and overflow_o are registered. Each is high for exactly the one cycle after the offending edge.
- ready_i is sampled only at posedge. valid_o is not combinationally dependent on ready_i.
- Sustained throughput is one word per WIDTH cycles with ready_i tied high.

## Structure
- Package deser_pkg holds:
  - the state enum typedef {IDLE, SHIFT};
  - default WIDTH/LOGWIDTH constants, taken from the shared parameters.vh so they match the serializer's tree width.
- No sub-module. Implement as a single module with one FSM/counter always block and one output-register always block.

## Test plan
All scenarios use WIDTH=8.
- Single word: send bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) with valid_i high for 8 cycles and ready_i=1. Expect data_o=0xA5 and valid_o high for exactly 1 cycle, starting the cycle after the 8th bit.
- Back-to-back: send 0x3C then 0xC3 as 16 contiguous valid bits with ready_i=1. Expect two valid_o pulses 8 cycles apart carrying 0x3C then 0xC3, and no abort.
- Abort: drop valid_i after 5 bits. Expect an abort_o pulse for 1 cycle and no valid_o. A following full word 0x0F is received correctly.
- Overflow and recovery: with ready_i=0, send 0x11 then 0x22. Expect data_o to stay 0x11 with valid_o held, and an overflow_o pulse after the 0x22 completion. Raise ready_i: 0x11 is consumed and valid_o drops.
- Simultaneous accept/complete: with valid_o=1 holding 0x55, set ready_i=1 in the same cycle 0x66 completes. Expect data_o=0x66, valid_o to stay 1, and overflow_o=0.
- Reset mid-word: assert reset for 1 cycle after 3 bits. Expect all outputs 0 and no abort. The next 0x81 is received cleanly.

Source files
------------

// File: rtl/shift_deserializer_pkg.sv
// deser_pkg: shared types and default sizing for the bit-serial deserializer.
//   state_e          - two-state word assembly FSM (IDLE, SHIFT)
//   DEFAULT_WIDTH    - default word width; must match the serializer tree width
//   DEFAULT_LOGWIDTH - log2(DEFAULT_WIDTH); sizes the bit counter
package deser_pkg;

  // Kept equal to the serializer's tree width so that both ends of the link
  // agree on the word size.
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_LOGWIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_deserializer.sv
// shift_deserializer: assembles WIDTH consecutive valid serial bits (LSB first)
// into a word and presents it through a one-entry valid/ready output register.
// Ports:
//   clk        in   bit clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   data_i     in   serial data bit, sampled when valid_i=1
//   valid_i    in   qualifies data_i; high for exactly WIDTH cycles per word
//   ready_i    in   consumer accepts data_o when valid_o & ready_i
//   data_o     out  assembled word, bit 0 = first received bit
//   valid_o    out  data_o holds an unconsumed word
//   abort_o    out  one-cycle pulse: valid_i dropped mid-word
//   overflow_o out  one-cycle pulse: completed word dropped, output register full
module shift_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LOGWIDTH = DEFAULT_LOGWIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             abort_o,
  output logic             overflow_o
);

  localparam logic [LOGWIDTH-1:0] CNT_LAST = LOGWIDTH'(WIDTH - 1);
  localparam logic [LOGWIDTH-1:0] CNT_ONE  = {{(LOGWIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [LOGWIDTH-1:0] cnt_q, cnt_d;
  // The last bit of a word is taken straight from data_i, so only WIDTH-1
  // bits ever need to be held.
  logic [WIDTH-2:0]    shreg_q, shreg_d;
  logic                abort_q, abort_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  logic                word_done;
  logic [WIDTH-1:0]    word_in;

  assign word_in = {data_i, shreg_q};

  // Next-state logic for the assembly FSM, bit counter and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          shreg_d[0] = data_i;
          cnt_d      = CNT_ONE;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!valid_i) begin
          // Frame ended early: discard the partial word.
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          shreg_d[cnt_q] = data_i;
          cnt_d          = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, shift register and abort pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      abort_q <= abort_d;
    end
  end

  // Next value of the one-entry output register and the overflow pulse.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (word_done) begin
      // A consumer taking the held word this cycle frees the slot for the
      // word completing in the same cycle.
      if (!valid_q || ready_i) begin
        data_d  = word_in;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register and overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign abort_o    = abort_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH=8): directed scenarios
// followed by random traffic, all checked against a queue-based word model.
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         data_i;
  logic         valid_i;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         abort_o;
  logic         overflow_o;

  int checks;
  int errors;

  // Reference model state
  bit           bits_q[$];
  logic [W-1:0] exp_data;
  logic         exp_valid;
  logic         exp_abort;
  logic         exp_ovf;

  shift_deserializer #(.WIDTH(W), .LOGWIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .abort_o    (abort_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level model: collect valid bits; WIDTH of them form a word,
  // a gap before that is an abort.
  task automatic model_update(input logic rst, input logic v, input logic d, input logic r);
    logic         done;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (rst) begin
      bits_q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_abort = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      exp_abort = 1'b0;
      exp_ovf   = 1'b0;
      if (v) begin
        bits_q.push_back(d);
        if (bits_q.size() == W) begin
          for (int i = 0; i < W; i++) word[i] = bits_q[i];
          bits_q.delete();
          done = 1'b1;
        end
      end else if (bits_q.size() > 0) begin
        exp_abort = 1'b1;
        bits_q.delete();
      end
      if (done) begin
        if (!exp_valid || r) begin
          exp_data  = word;
          exp_valid = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (exp_valid && r) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic d, input logic r);
    reset   = rst;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk);
    model_update(rst, v, d, r);
    #1;
    chk("valid_o", valid_o, exp_valid);
    chk("data_o", data_o, exp_data);
    chk("abort_o", abort_o, exp_abort);
    chk("overflow_o", overflow_o, exp_ovf);
    chk("abort_ovf_exclusive", abort_o & overflow_o, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r_early, input logic r_last);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, w[i], (i == W - 1) ? r_last : r_early);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_abort = 1'b0;
    exp_ovf   = 1'b0;
    reset     = 1'b1;
    valid_i   = 1'b0;
    data_i    = 1'b0;
    ready_i   = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", valid_o, 1'b0);
    chk("reset_data", data_o, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Single word 0xA5
    send_word(8'hA5, 1'b1, 1'b1);
    chk("single_data", data_o, 8'hA5);
    chk("single_valid", valid_o, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_valid_one_cycle", valid_o, 1'b0);

    // Back-to-back 0x3C, 0xC3
    send_word(8'h3C, 1'b1, 1'b1);
    chk("b2b_first", data_o, 8'h3C);
    send_word(8'hC3, 1'b1, 1'b1);
    chk("b2b_second", data_o, 8'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after 5 bits, then 0x0F
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'(i & 1), 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_pulse", abort_o, 1'b1);
    chk("abort_no_valid", valid_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_one_cycle", abort_o, 1'b0);
    send_word(8'h0F, 1'b1, 1'b1);
    chk("after_abort", data_o, 8'h0F);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow and recovery
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("ovf_pulse", overflow_o, 1'b1);
    chk("ovf_keep_data", data_o, 8'h11);
    chk("ovf_keep_valid", valid_o, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drained", valid_o, 1'b0);

    // Simultaneous accept and completion
    send_word(8'h55, 1'b0, 1'b0);
    chk("sim_hold", data_o, 8'h55);
    send_word(8'h66, 1'b0, 1'b1);
    chk("sim_data", data_o, 8'h66);
    chk("sim_valid", valid_o, 1'b1);
    chk("sim_no_ovf", overflow_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_data", data_o, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_no_abort", abort_o, 1'b0);
    send_word(8'h81, 1'b1, 1'b1);
    chk("after_rst", data_o, 8'h81);

    // Random traffic: mostly long valid runs, random ready, rare reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 11) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
